mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single shared memory.
// Data requests win by default; a waiting fetch is guaranteed a slot after STARVE_MAX data grants.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,

    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              stall_o
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    starve_cnt_q;
    logic [CNT_W-1:0]    starve_cnt_d;
    logic                grant_dm;
    logic                grant_if;

    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                if_ack_q;
    logic                dm_ack_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   dm_rdata_q;

    // Arbitration decision, only meaningful in IDLE; also computes the starvation counter update.
    always_comb begin
        grant_dm     = 1'b0;
        grant_if     = 1'b0;
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE) begin
            if (dm_req_i && (!if_req_i || (starve_cnt_q < CNT_MAX))) begin
                grant_dm = 1'b1;
                if (if_req_i) begin
                    starve_cnt_d = starve_cnt_q + CNT_W'(1);
                end
            end else if (if_req_i) begin
                grant_if     = 1'b1;
                starve_cnt_d = '0;
            end
        end
    end

    // Transaction FSM; every output comes straight from a register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            case (state_q)
                IDLE: begin
                    if (grant_dm) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we_i;
                        mem_addr_q  <= dm_addr_i;
                        mem_wdata_q <= dm_wdata_i;
                        state_q     <= BUSY_DM;
                    end else if (grant_if) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr_i;
                        mem_wdata_q <= '0;
                        state_q     <= BUSY_IF;
                    end
                end
                BUSY_IF: begin
                    if (mem_ack_i) begin
                        mem_req_q  <= 1'b0;
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= mem_rdata_i;
                        state_q    <= RESP;
                    end
                end
                BUSY_DM: begin
                    if (mem_ack_i) begin
                        mem_req_q  <= 1'b0;
                        dm_ack_q   <= 1'b1;
                        dm_rdata_q <= mem_we_q ? '0 : mem_rdata_i;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if_ack_q <= 1'b0;
                    dm_ack_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_ack_o    = if_ack_q;
    assign dm_ack_o    = dm_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;

    // Pipeline stall is intentionally combinational so the core sees it in the request cycle.
    assign stall_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by randomized two-port traffic.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int M_IDLE = 0;
    localparam int M_BUSY = 1;
    localparam int M_RESP = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_ack_o;
    logic [DW-1:0] if_rdata_o;
    logic          dm_req_i;
    logic          dm_we_i;
    logic [AW-1:0] dm_addr_i;
    logic [DW-1:0] dm_wdata_i;
    logic          dm_ack_o;
    logic [DW-1:0] dm_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_rdata_i;
    logic          stall_o;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] if_q[$];
    logic [DW-1:0] dm_q[$];
    int            ack_log[$];
    int            n_dm;
    int            exp_order[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory contents as seen by the bench: a fixed scramble of the address.
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    task automatic if_issue(input logic [AW-1:0] a);
        if_req_i  = 1'b1;
        if_addr_i = a;
        if_q.push_back(mem_fn(a));
    endtask

    task automatic dm_issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dm_req_i   = 1'b1;
        dm_we_i    = we;
        dm_addr_i  = a;
        dm_wdata_i = d;
        dm_q.push_back(we ? '0 : mem_fn(a));
    endtask

    // ---------------- reference model / monitor ----------------
    int            m_phase  = M_IDLE;
    bit            m_own_dm = 1'b0;
    int            m_starve = 0;
    logic          e_we     = 1'b0;
    logic [AW-1:0] e_addr   = '0;
    logic [DW-1:0] e_wdata  = '0;
    logic [DW-1:0] e_if_rdata = '0;
    logic [DW-1:0] e_dm_rdata = '0;
    logic          p_rst = 1'b1, p_if_req = 1'b0, p_dm_req = 1'b0, p_dm_we = 1'b0, p_mem_ack = 1'b0;
    logic [AW-1:0] p_if_addr = '0, p_dm_addr = '0;
    logic [DW-1:0] p_dm_wdata = '0;

    always @(negedge clk) begin
        if (p_rst) begin
            m_phase    = M_IDLE;
            m_starve   = 0;
            e_if_rdata = '0;
            e_dm_rdata = '0;
            chk("reset mem_we", 32'(mem_we_o), 32'd0);
            chk("reset mem_addr", mem_addr_o, 32'd0);
            chk("reset mem_wdata", mem_wdata_o, 32'd0);
        end else begin
            case (m_phase)
                M_IDLE: begin
                    if (p_dm_req && (!p_if_req || m_starve < STARVE_MAX)) begin
                        m_own_dm = 1'b1;
                        if (p_if_req && m_starve < STARVE_MAX) m_starve++;
                        e_we = p_dm_we; e_addr = p_dm_addr; e_wdata = p_dm_wdata;
                        m_phase = M_BUSY;
                    end else if (p_if_req) begin
                        m_own_dm = 1'b0;
                        m_starve = 0;
                        e_we = 1'b0; e_addr = p_if_addr; e_wdata = '0;
                        m_phase = M_BUSY;
                    end
                end
                M_BUSY: begin
                    if (p_mem_ack) begin
                        m_phase = M_RESP;
                        if (m_own_dm) begin
                            chk("dm ack has pending request", 32'(dm_q.size() > 0), 32'd1);
                            if (dm_q.size() > 0) e_dm_rdata = dm_q.pop_front();
                        end else begin
                            chk("if ack has pending request", 32'(if_q.size() > 0), 32'd1);
                            if (if_q.size() > 0) e_if_rdata = if_q.pop_front();
                        end
                    end
                end
                default: m_phase = M_IDLE;
            endcase
        end
        chk("mem_req", 32'(mem_req_o), 32'(m_phase == M_BUSY));
        if (m_phase == M_BUSY) begin
            chk("mem_we", 32'(mem_we_o), 32'(e_we));
            chk("mem_addr", mem_addr_o, e_addr);
            chk("mem_wdata", mem_wdata_o, e_wdata);
        end
        chk("if_ack", 32'(if_ack_o), 32'(m_phase == M_RESP && !m_own_dm));
        chk("dm_ack", 32'(dm_ack_o), 32'(m_phase == M_RESP && m_own_dm));
        chk("if_rdata", if_rdata_o, e_if_rdata);
        chk("dm_rdata", dm_rdata_o, e_dm_rdata);
        chk("stall", 32'(stall_o), 32'((if_req_i && !if_ack_o) || (dm_req_i && !dm_ack_o)));
        if (if_ack_o) ack_log.push_back(1);
        if (dm_ack_o) ack_log.push_back(2);
        p_rst = rst_i; p_if_req = if_req_i; p_dm_req = dm_req_i; p_dm_we = dm_we_i;
        p_mem_ack = mem_ack_i; p_if_addr = if_addr_i; p_dm_addr = dm_addr_i; p_dm_wdata = dm_wdata_i;
    end

    // ---------------- stimulus agents ----------------
    task automatic mem_model(input int cycles);
        int lat = -1;
        for (int c = 0; c < cycles; c++) begin
            tick();
            mem_ack_i = 1'b0;
            if (mem_req_o) begin
                if (lat < 0) lat = int'($urandom_range(0, 3));
                if (lat == 0) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_fn(mem_addr_o);
                    lat = -1;
                end else begin
                    lat--;
                end
            end else begin
                lat = -1;
                if ($urandom_range(0, 7) == 0) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = $urandom();
                end
            end
        end
        mem_ack_i = 1'b0;
    endtask

    task automatic if_gen(input int cycles);
        for (int c = 0; c < cycles + 400; c++) begin
            tick();
            if (if_req_i && if_ack_o) begin
                if (c < cycles && $urandom_range(0, 3) == 0) if_issue(rand_addr());
                else if_req_i = 1'b0;
            end else if (!if_req_i) begin
                if (c >= cycles) break;
                if ($urandom_range(0, 2) == 0) if_issue(rand_addr());
            end
        end
    endtask

    task automatic dm_gen(input int cycles);
        for (int c = 0; c < cycles + 400; c++) begin
            tick();
            if (dm_req_i && dm_ack_o) begin
                if (c < cycles && $urandom_range(0, 1) == 0)
                    dm_issue(1'($urandom_range(0, 1)), rand_addr(), $urandom());
                else dm_req_i = 1'b0;
            end else if (!dm_req_i) begin
                if (c >= cycles) break;
                if ($urandom_range(0, 1) == 0)
                    dm_issue(1'($urandom_range(0, 1)), rand_addr(), $urandom());
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_we_i = 1'b0;
        dm_addr_i = '0; dm_wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (3) tick();
        rst_i = 1'b0;
        chk("init if_ack", 32'(if_ack_o), 32'd0);
        chk("init dm_ack", 32'(dm_ack_o), 32'd0);
        chk("init mem_req", 32'(mem_req_o), 32'd0);
        chk("init stall", 32'(stall_o), 32'd0);

        // single fetch, memory answers two cycles after the request appears
        if_issue(32'h40);
        if_q.pop_back();
        if_q.push_back(32'h8C220004);
        tick();
        chk("fetch mem_req", 32'(mem_req_o), 32'd1);
        chk("fetch mem_addr", mem_addr_o, 32'h40);
        chk("fetch mem_we", 32'(mem_we_o), 32'd0);
        chk("fetch stall c1", 32'(stall_o), 32'd1);
        tick();
        chk("fetch stall c2", 32'(stall_o), 32'd1);
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h8C220004;
        chk("fetch stall c3", 32'(stall_o), 32'd1);
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        chk("fetch if_ack", 32'(if_ack_o), 32'd1);
        chk("fetch if_rdata", if_rdata_o, 32'h8C220004);
        chk("fetch stall on ack", 32'(stall_o), 32'd0);
        if_req_i = 1'b0;
        tick();
        chk("fetch ack one cycle", 32'(if_ack_o), 32'd0);
        chk("fetch rdata held", if_rdata_o, 32'h8C220004);

        // write, memory acks in the first busy cycle
        dm_issue(1'b1, 32'h10, 32'hDEADBEEF);
        tick();
        chk("write mem_we", 32'(mem_we_o), 32'd1);
        chk("write mem_wdata", mem_wdata_o, 32'hDEADBEEF);
        chk("write mem_addr", mem_addr_o, 32'h10);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h13579BDF;
        tick();
        mem_ack_i = 1'b0;
        chk("write dm_ack at N+2", 32'(dm_ack_o), 32'd1);
        chk("write dm_rdata zero", dm_rdata_o, 32'd0);
        dm_req_i = 1'b0; dm_we_i = 1'b0;
        tick();
        chk("write ack one cycle", 32'(dm_ack_o), 32'd0);

        // spurious memory ack while idle
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
        tick();
        mem_ack_i = 1'b0;
        chk("spurious if_ack", 32'(if_ack_o), 32'd0);
        chk("spurious dm_ack", 32'(dm_ack_o), 32'd0);
        chk("spurious mem_req", 32'(mem_req_o), 32'd0);
        chk("spurious if_rdata kept", if_rdata_o, 32'h8C220004);

        // contention: fetch held while data keeps issuing fresh requests
        ack_log.delete();
        if_issue(32'h100);
        dm_issue(1'b0, 32'h200, 32'h0);
        n_dm = 1;
        fork
            mem_model(120);
            begin
                for (int c = 0; c < 110; c++) begin
                    tick();
                    if (dm_ack_o) begin
                        if (n_dm < 5) begin
                            dm_issue(1'(n_dm % 2), 32'h200 + 32'(4 * n_dm), 32'hA5000000 + 32'(n_dm));
                            n_dm++;
                        end else begin
                            dm_req_i = 1'b0;
                        end
                    end
                    if (if_ack_o) if_req_i = 1'b0;
                    if (!if_req_i && !dm_req_i) break;
                end
            end
        join
        exp_order = '{2, 2, 2, 2, 1, 2};
        chk("contention ack count", 32'(ack_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < ack_log.size()) chk($sformatf("grant order %0d", i), 32'(ack_log[i]), 32'(exp_order[i]));
        end

        // reset in the middle of a data transaction
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h30;
        tick();
        chk("abort busy mem_req", 32'(mem_req_o), 32'd1);
        rst_i = 1'b1; dm_req_i = 1'b0;
        tick();
        rst_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        chk("abort mem_req", 32'(mem_req_o), 32'd0);
        chk("abort mem_addr", mem_addr_o, 32'd0);
        chk("abort dm_rdata", dm_rdata_o, 32'd0);
        chk("abort if_rdata", if_rdata_o, 32'd0);
        tick();
        mem_ack_i = 1'b0;
        chk("abort no dm_ack", 32'(dm_ack_o), 32'd0);
        chk("abort stays idle", 32'(mem_req_o), 32'd0);
        if_issue(32'h44);
        tick();
        chk("post-reset grant", 32'(mem_req_o), 32'd1);
        chk("post-reset addr", mem_addr_o, 32'h44);
        mem_ack_i = 1'b1; mem_rdata_i = mem_fn(32'h44);
        tick();
        mem_ack_i = 1'b0;
        chk("post-reset if_ack", 32'(if_ack_o), 32'd1);
        chk("post-reset if_rdata", if_rdata_o, mem_fn(32'h44));
        if_req_i = 1'b0;
        tick();

        // randomized traffic on both ports
        fork
            if_gen(3000);
            dm_gen(3000);
            mem_model(3500);
        join
        repeat (3) tick();
        chk("drain reqs low", 32'(if_req_i | dm_req_i), 32'd0);
        chk("if queue empty", 32'(if_q.size()), 32'd0);
        chk("dm queue empty", 32'(dm_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
